// File: rtl/vx_issue_arbiter.sv
// Round-robin issue scheduler with per-unit credit tracking and a 1-entry output register.
// Optional performance counters are enabled by defining ISSUE_ARB_PERF_EN.
module vx_issue_arbiter #(
   parameter int unsigned NUM_WARPS = 4,
   parameter int unsigned NUM_UNITS = 6,
   parameter int unsigned EX_BITS   = 3,
   parameter int unsigned CREDITS   = 2,
   localparam int unsigned NW_BITS  = $clog2(NUM_WARPS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_WARPS-1:0]          req_valid,
   input  logic [NUM_WARPS*EX_BITS-1:0]  req_ex_type,
   output logic [NUM_WARPS-1:0]          req_ready,
   output logic                          issue_valid,
   output logic [NW_BITS-1:0]            issue_wid,
   output logic [EX_BITS-1:0]            issue_ex_type,
   input  logic                          issue_ready,
   input  logic [NUM_UNITS-1:0]          unit_release,
   output logic [NUM_UNITS-1:0]          credit_avail
`ifdef ISSUE_ARB_PERF_EN
   ,
   output logic [31:0]                   perf_issue_cnt,
   output logic [31:0]                   perf_stall_cnt
`endif
);

   localparam int unsigned CW = $clog2(CREDITS + 1);

   logic [CW-1:0]        credit [1:NUM_UNITS-1];
   logic [NW_BITS-1:0]   rr_ptr;
   logic [EX_BITS-1:0]   wtype [NUM_WARPS];
   logic [NUM_WARPS-1:0] eligible;
   logic                 load;
   logic                 grant;
   logic                 grant_any;
   logic [NW_BITS-1:0]   win;
   logic [NW_BITS-1:0]   idx;
   logic [EX_BITS-1:0]   win_type;
   logic                 unused_rel0;

   // ALU never consumes a credit, so its release bit carries no information
   assign unused_rel0 = unit_release[0];

   always_comb begin
      credit_avail = '1;
      for (int unsigned u = 1; u < NUM_UNITS; u++)
         credit_avail[u] = (credit[u] != '0);
   end

   always_comb begin
      eligible = '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         wtype[w]    = req_ex_type[w*EX_BITS +: EX_BITS];
         eligible[w] = req_valid[w] && (32'(wtype[w]) < NUM_UNITS) &&
                       ((wtype[w] == '0) || credit_avail[wtype[w]]);
      end
   end

   assign load = !issue_valid || issue_ready;

   // First eligible warp at or after rr_ptr; index wraps naturally (power-of-2 warps)
   always_comb begin
      grant_any = 1'b0;
      win       = '0;
      idx       = '0;
      for (int unsigned i = 0; i < NUM_WARPS; i++) begin
         idx = rr_ptr + NW_BITS'(i);
         if (!grant_any && eligible[idx]) begin
            grant_any = 1'b1;
            win       = idx;
         end
      end
      win_type  = wtype[win];
      grant     = reset && load && grant_any;
      req_ready = '0;
      if (grant)
         req_ready[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issue_valid   <= 1'b0;
         issue_wid     <= '0;
         issue_ex_type <= '0;
         rr_ptr        <= '0;
      end else if (load) begin
         issue_valid <= grant;
         if (grant) begin
            issue_wid     <= win;
            issue_ex_type <= win_type;
            rr_ptr        <= win + NW_BITS'(1);
         end
      end
   end

   // Simultaneous take and return cancel; a return into a full counter is dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned u = 1; u < NUM_UNITS; u++)
            credit[u] <= CW'(CREDITS);
      end else begin
         for (int unsigned u = 1; u < NUM_UNITS; u++) begin
            if (grant && (win_type == EX_BITS'(u)) && !unit_release[u])
               credit[u] <= credit[u] - CW'(1);
            else if (unit_release[u] && !(grant && (win_type == EX_BITS'(u))) &&
                     (credit[u] != CW'(CREDITS)))
               credit[u] <= credit[u] + CW'(1);
         end
      end
   end

`ifdef ISSUE_ARB_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (issue_valid && issue_ready)
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         if ((|req_valid) && !grant)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`else
   // Performance counters not built; arbitration is unaffected.
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (reset) begin
         for (int unsigned w = 0; w < NUM_WARPS; w++)
            assert (!(req_valid[w] && (32'(wtype[w]) >= NUM_UNITS)))
               else $warning("vx_issue_arbiter: warp %0d requests unknown unit %0d", w, wtype[w]);
         for (int unsigned u = 1; u < NUM_UNITS; u++)
            assert (!(unit_release[u] && (credit[u] == CW'(CREDITS)) &&
                      !(grant && (win_type == EX_BITS'(u)))))
               else $error("vx_issue_arbiter: credit return to full unit %0d", u);
      end
   end
`endif

endmodule

// File: tb/tb_vx_issue_arbiter.sv
// Self-checking bench for vx_issue_arbiter: directed vector table, hand sequences for
// backpressure/credit/reset corners, and randomized traffic against a behavioural model.
module tb_vx_issue_arbiter;

   localparam int NW = 4;
   localparam int NU = 6;
   localparam int EB = 3;
   localparam int CR = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NW-1:0]     req_valid;
   logic [NW*EB-1:0]  req_ex_type;
   logic [NW-1:0]     req_ready;
   logic              issue_valid;
   logic [1:0]        issue_wid;
   logic [EB-1:0]     issue_ex_type;
   logic              issue_ready;
   logic [NU-1:0]     unit_release;
   logic [NU-1:0]     credit_avail;
`ifdef ISSUE_ARB_PERF_EN
   logic [31:0]       perf_issue_cnt;
   logic [31:0]       perf_stall_cnt;
   logic [31:0]       m_issue;
   logic [31:0]       m_stall;
`endif

   always #5 clk = ~clk;

   vx_issue_arbiter #(.NUM_WARPS(NW), .NUM_UNITS(NU), .EX_BITS(EB), .CREDITS(CR)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ex_type   (req_ex_type),
      .req_ready     (req_ready),
      .issue_valid   (issue_valid),
      .issue_wid     (issue_wid),
      .issue_ex_type (issue_ex_type),
      .issue_ready   (issue_ready),
      .unit_release  (unit_release),
      .credit_avail  (credit_avail)
`ifdef ISSUE_ARB_PERF_EN
      ,
      .perf_issue_cnt(perf_issue_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model: what the output register holds, where the scan starts, free slots per unit
   bit m_valid;
   int m_wid;
   int m_type;
   int m_rr;
   int m_cred [NU];

   typedef struct {
      logic [NW-1:0]    rv;
      logic [NW*EB-1:0] ty;
      logic             ir;
      logic [NU-1:0]    rel;
      logic [NW-1:0]    exp_rdy;
      string            name;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_wid = 0; m_type = 0; m_rr = 0;
      for (int u = 0; u < NU; u++) m_cred[u] = CR;
`ifdef ISSUE_ARB_PERF_EN
      m_issue = 0; m_stall = 0;
`endif
   endtask

   function automatic int model_winner(input logic [NW-1:0] rv, input logic [NW*EB-1:0] ty,
                                       input logic ir);
      logic [NW*EB-1:0] tv;
      int t;
      int w;
      if (m_valid && !ir) return -1;
      tv = ty;
      for (int k = 0; k < NW; k++) begin
         w = (m_rr + k) % NW;
         t = int'(tv[w*EB +: EB]);
         if (rv[w] && t < NU && (t == 0 || m_cred[t] > 0)) return w;
      end
      return -1;
   endfunction

   task automatic check_state();
      logic [NU-1:0] exp_ca;
      exp_ca = '1;
      for (int u = 1; u < NU; u++) exp_ca[u] = (m_cred[u] != 0);
      chk("issue_valid", 32'(issue_valid), 32'(m_valid));
      chk("issue_wid", 32'(issue_wid), 32'(m_wid));
      chk("issue_ex_type", 32'(issue_ex_type), 32'(m_type));
      chk("credit_avail", 32'(credit_avail), 32'(exp_ca));
`ifdef ISSUE_ARB_PERF_EN
      chk("perf_issue_cnt", perf_issue_cnt, m_issue);
      chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
   endtask

   // One cycle: check registered state, drive inputs, check grant, advance the model
   task automatic step(input logic [NW-1:0] rv, input logic [NW*EB-1:0] ty, input logic ir,
                       input logic [NU-1:0] rel);
      int g;
      int gt;
      logic [NW-1:0] exp_rdy;
      @(negedge clk);
      check_state();
      req_valid = rv; req_ex_type = ty; issue_ready = ir; unit_release = rel;
      #1;
      g = model_winner(rv, ty, ir);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
`ifdef ISSUE_ARB_PERF_EN
      if (m_valid && ir) m_issue++;
      if ((|rv) && g < 0) m_stall++;
`endif
      gt = (g >= 0) ? int'(ty[g*EB +: EB]) : -1;
      if (!m_valid || ir) begin
         m_valid = (g >= 0);
         if (g >= 0) begin
            m_wid = g; m_type = gt; m_rr = (g + 1) % NW;
         end
      end
      for (int u = 1; u < NU; u++) begin
         if (gt == u && !rel[u]) m_cred[u]--;
         else if (rel[u] && gt != u && m_cred[u] < CR) m_cred[u]++;
      end
   endtask

   task automatic add(input logic [NW-1:0] rv, input logic [NW*EB-1:0] ty, input logic ir,
                      input logic [NU-1:0] rel, input logic [NW-1:0] exp_rdy, input string name);
      vec_t v;
      v.rv = rv; v.ty = ty; v.ir = ir; v.rel = rel; v.exp_rdy = exp_rdy; v.name = name;
      tbl.push_back(v);
   endtask

   initial begin
      logic [NW-1:0]    rv;
      logic [NW*EB-1:0] ty;
      logic [NU-1:0]    rel;
      int               r;

      // Round robin over four ALU warps, then warp1 LSU credit exhaustion and refill,
      // then an LSU-blocked warp0 skipped in favour of ALU warp2
      for (int i = 0; i < 6; i++) add(4'hf, 12'h000, 1'b1, 6'h00, 4'(1 << (i % 4)), "rr");
      add(4'b0010, 12'h008, 1'b1, 6'h00, 4'b0010, "cred_a");
      add(4'b0010, 12'h008, 1'b1, 6'h00, 4'b0010, "cred_b");
      add(4'b0010, 12'h008, 1'b1, 6'h00, 4'b0000, "cred_empty");
      add(4'b0010, 12'h008, 1'b1, 6'h02, 4'b0000, "cred_rel_cycle");
      add(4'b0010, 12'h008, 1'b1, 6'h00, 4'b0010, "cred_after_rel");
      add(4'b1000, 12'h000, 1'b1, 6'h00, 4'b1000, "rr_to_zero");
      add(4'b0101, 12'h001, 1'b1, 6'h00, 4'b0100, "skip_lsu");

      // Reset held three cycles with requests pending
      reset = 1'b0; req_valid = 4'hf; req_ex_type = '0; issue_ready = 1'b1; unit_release = '0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_issue_valid", 32'(issue_valid), 32'd0);
         chk("rst_credit_avail", 32'(credit_avail), 32'h3f);
      end
      req_valid = '0;
      reset = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].rv, tbl[i].ty, tbl[i].ir, tbl[i].rel);
         chk(tbl[i].name, 32'(req_ready), 32'(tbl[i].exp_rdy));
      end

      // Backpressure: held instruction stays put, no grants
      for (int i = 0; i < 5; i++) begin
         step(4'hf, 12'h000, 1'b0, 6'h00);
         chk("bp_no_grant", 32'(req_ready), 32'd0);
      end

      // Unit 3: take one, then take+return (no change), then drain to empty
      step(4'b1000, 12'h600, 1'b1, 6'h00);
      step(4'b1000, 12'h600, 1'b1, 6'h08);
      chk("mul_grant_rel", 32'(req_ready), 32'b1000);
      step(4'b1000, 12'h600, 1'b1, 6'h00);
      chk("mul_last_credit", 32'(req_ready), 32'b1000);
      step(4'b1000, 12'h600, 1'b1, 6'h00);
      chk("mul_empty", 32'(req_ready), 32'd0);
      step(4'b0000, 12'h000, 1'b1, 6'h08);

      // Unknown unit on warp3 is never granted
      for (int i = 0; i < 4; i++) begin
         step(4'b1000, 12'he00, 1'b1, 6'h00);
         chk("bad_type", 32'(req_ready), 32'd0);
      end

      // Reset while an instruction is held: dropped at once, credits reload
      step(4'b0001, 12'h000, 1'b1, 6'h00);
      @(negedge clk);
      check_state();
      req_valid = '0; issue_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("midrst_issue_valid", 32'(issue_valid), 32'd0);
      chk("midrst_credit_avail", 32'(credit_avail), 32'h3f);
      model_reset();
      @(negedge clk);
      reset = 1'b1;

      // Random traffic; returns only to units with a slot outstanding
      for (int n = 0; n < 400; n++) begin
         rv = 4'($urandom);
         for (int w = 0; w < NW; w++) begin
            r = $urandom_range(0, 15);
            ty[w*EB +: EB] = (r >= 8) ? 3'($urandom_range(0, 5)) : 3'(r);
         end
         rel = '0;
         for (int u = 1; u < NU; u++)
            if (m_cred[u] < CR && $urandom_range(0, 2) == 0) rel[u] = 1'b1;
         step(rv, ty, ($urandom_range(0, 3) != 0), rel);
      end
      @(negedge clk);
      check_state();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
